// File: rtl/genius_controle_param.sv
// rtl/genius_controle_param.sv - parametrised control unit for the sequence-memory game
// Owns address, round, lives and a shared in-state timer; all outputs decode the state register.
module genius_controle_param #(
  parameter int ADDR_W   = 4,
  parameter int T_ON     = 500,
  parameter int T_OFF    = 250,
  parameter int T_JOGADA = 5000,
  parameter int VIDAS    = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              iniciar,
  input  logic              jogada_feita,
  input  logic              jogada_correta,
  input  logic [ADDR_W-1:0] nivel_rodadas,
  input  logic              nivel_tempo,
  input  logic              modo_grava,
  output logic [ADDR_W-1:0] endereco,
  output logic [ADDR_W-1:0] rodada,
  output logic [2:0]        vidas,
  output logic              registraR,
  output logic              gravaM,
  output logic              ativa_leds_mem,
  output logic              ativa_leds_jog,
  output logic              toca,
  output logic              vez_jogador,
  output logic              nova_jogada,
  output logic              erro,
  output logic              ganhou,
  output logic              perdeu,
  output logic              timeout,
  output logic              pronto,
  output logic [4:0]        db_estado
);

  localparam int TMAX_A = (T_ON > T_OFF) ? T_ON : T_OFF;
  localparam int TMAX   = (TMAX_A > T_JOGADA) ? TMAX_A : T_JOGADA;
  localparam int TW     = $clog2(TMAX + 1);

  localparam logic [TW-1:0] TON_LAST  = TW'(T_ON - 1);
  localparam logic [TW-1:0] TOFF_LAST = TW'(T_OFF - 1);
  localparam logic [TW-1:0] TJOG_LAST = TW'(T_JOGADA - 1);
  localparam logic [TW-1:0] TJOG_HALF = TW'(T_JOGADA / 2 - 1);

  typedef enum logic [4:0] {
    INICIAL         = 5'h00,
    PREPARA         = 5'h01,
    PAUSA           = 5'h02,
    MOSTRA          = 5'h03,
    INICIO_JOGADA   = 5'h05,
    ESPERA_JOGADA   = 5'h06,
    REGISTRA        = 5'h07,
    FEEDBACK        = 5'h08,
    ERRO_VIDA       = 5'h0A,
    ESPERA_GRAVACAO = 5'h0B,
    GRAVA           = 5'h0C,
    MOSTRA_GRAVACAO = 5'h0D,
    PROXIMA_RODADA  = 5'h0E,
    GANHOU          = 5'h10,
    PERDEU          = 5'h11,
    TIMEOUT         = 5'h12
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] endereco_q, endereco_d;
  logic [ADDR_W-1:0] rodada_q, rodada_d;
  logic [ADDR_W-1:0] nivel_q, nivel_d;
  logic [2:0]        vidas_q, vidas_d;
  logic              tempo_q, tempo_d;
  logic              grava_q, grava_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              on_last;
  logic [TW-1:0]     jog_last;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= INICIAL;
      endereco_q <= '0;
      rodada_q   <= '0;
      nivel_q    <= '0;
      vidas_q    <= 3'(VIDAS);
      tempo_q    <= 1'b0;
      grava_q    <= 1'b0;
      tmr_q      <= '0;
    end else begin
      state_q    <= state_d;
      endereco_q <= endereco_d;
      rodada_q   <= rodada_d;
      nivel_q    <= nivel_d;
      vidas_q    <= vidas_d;
      tempo_q    <= tempo_d;
      grava_q    <= grava_d;
      tmr_q      <= tmr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    endereco_d = endereco_q;
    rodada_d   = rodada_q;
    nivel_d    = nivel_q;
    vidas_d    = vidas_q;
    tempo_d    = tempo_q;
    grava_d    = grava_q;
    on_last    = (tmr_q == TON_LAST);
    jog_last   = tempo_q ? TJOG_HALF : TJOG_LAST;

    case (state_q)
      INICIAL: if (iniciar) state_d = PREPARA;
      PREPARA: begin
        endereco_d = '0;
        rodada_d   = '0;
        vidas_d    = 3'(VIDAS);
        nivel_d    = nivel_rodadas;
        tempo_d    = nivel_tempo;
        grava_d    = modo_grava;
        state_d    = PAUSA;
      end
      PAUSA: if (tmr_q == TOFF_LAST) state_d = MOSTRA;
      MOSTRA: begin
        if (on_last) begin
          if (endereco_q == rodada_q) begin
            state_d = INICIO_JOGADA;
          end else begin
            endereco_d = endereco_q + ADDR_W'(1);
            state_d    = PAUSA;
          end
        end
      end
      INICIO_JOGADA: begin
        endereco_d = '0;
        state_d    = ESPERA_JOGADA;
      end
      // A press on the last allowed cycle beats the timeout
      ESPERA_JOGADA: begin
        if (jogada_feita)           state_d = REGISTRA;
        else if (tmr_q == jog_last) state_d = TIMEOUT;
      end
      REGISTRA: state_d = FEEDBACK;
      FEEDBACK: begin
        if (on_last) begin
          if (!jogada_correta) begin
            if (vidas_q > 3'd1) begin
              vidas_d = vidas_q - 3'd1;
              state_d = ERRO_VIDA;
            end else begin
              vidas_d = 3'd0;
              state_d = PERDEU;
            end
          end else if (endereco_q < rodada_q) begin
            endereco_d = endereco_q + ADDR_W'(1);
            state_d    = ESPERA_JOGADA;
          end else if (rodada_q == nivel_q) begin
            state_d = GANHOU;
          end else if (grava_q) begin
            endereco_d = endereco_q + ADDR_W'(1);
            state_d    = ESPERA_GRAVACAO;
          end else begin
            state_d = PROXIMA_RODADA;
          end
        end
      end
      ERRO_VIDA: begin
        if (on_last) begin
          endereco_d = '0;
          state_d    = PAUSA;
        end
      end
      ESPERA_GRAVACAO: if (jogada_feita) state_d = GRAVA;
      GRAVA:           state_d = MOSTRA_GRAVACAO;
      MOSTRA_GRAVACAO: if (on_last) state_d = PROXIMA_RODADA;
      PROXIMA_RODADA: begin
        rodada_d   = rodada_q + ADDR_W'(1);
        endereco_d = '0;
        state_d    = grava_q ? INICIO_JOGADA : PAUSA;
      end
      GANHOU, PERDEU, TIMEOUT: if (iniciar) state_d = PREPARA;
      default: state_d = INICIAL;
    endcase

    tmr_d = (state_d != state_q) ? '0 : tmr_q + TW'(1);
  end

  assign endereco       = endereco_q;
  assign rodada         = rodada_q;
  assign vidas          = vidas_q;
  assign db_estado      = state_q;
  assign registraR      = (state_q == REGISTRA);
  assign gravaM         = (state_q == GRAVA);
  assign ativa_leds_mem = (state_q == MOSTRA) || (state_q == MOSTRA_GRAVACAO);
  assign ativa_leds_jog = (state_q == FEEDBACK);
  assign toca           = ativa_leds_mem || ativa_leds_jog;
  assign vez_jogador    = (state_q == ESPERA_JOGADA);
  assign nova_jogada    = (state_q == ESPERA_GRAVACAO);
  assign erro           = (state_q == ERRO_VIDA);
  assign ganhou         = (state_q == GANHOU);
  assign timeout        = (state_q == TIMEOUT);
  assign perdeu         = (state_q == PERDEU) || (state_q == TIMEOUT);
  assign pronto         = ganhou || perdeu;

endmodule

// File: tb/tb_genius_controle_param.sv
// tb/tb_genius_controle_param.sv - directed bench for genius_controle_param
// A scripted player drives presses; outcomes are checked against hand-computed values.
module tb_genius_controle_param;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iniciar = 1'b0;
  logic       jogada_feita = 1'b0;
  logic       jogada_correta = 1'b0;
  logic [3:0] nivel_rodadas = '0;
  logic       nivel_tempo = 1'b0;
  logic       modo_grava = 1'b0;
  logic [3:0] endereco, rodada;
  logic [2:0] vidas;
  logic       registraR, gravaM, ativa_leds_mem, ativa_leds_jog, toca;
  logic       vez_jogador, nova_jogada, erro, ganhou, perdeu, timeout, pronto;
  logic [4:0] db_estado;

  genius_controle_param #(
    .ADDR_W(4), .T_ON(4), .T_OFF(2), .T_JOGADA(20), .VIDAS(2)
  ) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar),
    .jogada_feita(jogada_feita), .jogada_correta(jogada_correta),
    .nivel_rodadas(nivel_rodadas), .nivel_tempo(nivel_tempo), .modo_grava(modo_grava),
    .endereco(endereco), .rodada(rodada), .vidas(vidas),
    .registraR(registraR), .gravaM(gravaM), .ativa_leds_mem(ativa_leds_mem),
    .ativa_leds_jog(ativa_leds_jog), .toca(toca), .vez_jogador(vez_jogador),
    .nova_jogada(nova_jogada), .erro(erro), .ganhou(ganhou), .perdeu(perdeu),
    .timeout(timeout), .pronto(pronto), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  int n_mostra, mostra_min, mostra_max, erro_cyc, n_grava, late, replay_addr;
  int vidas_erro, esp_max, strobe_bad;
  int grava_addr[4];

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic start_game(input int nivel, input bit tempo, input bit grava);
    @(negedge clock);
    nivel_rodadas = 4'(nivel);
    nivel_tempo   = tempo;
    modo_grava    = grava;
    iniciar       = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    check("prepara", db_estado, 1);
  endtask

  // press_at: press on that cycle of each play wait (0 = never press)
  task automatic run(input string tag, input int press_at, input int n_wrong,
                     input int stop_st, input int stop_addr, input int budget);
    int run_m, run_e, wrongs, prev, st;
    bit done, wrong;
    n_mostra = 0; mostra_min = 1000; mostra_max = 0; erro_cyc = 0; n_grava = 0;
    late = 0; replay_addr = -1; vidas_erro = -1; esp_max = 0; strobe_bad = 0;
    for (int k = 0; k < 4; k++) grava_addr[k] = -1;
    run_m = 0; run_e = 0; wrongs = 0; prev = -1; done = 1'b0;
    for (int cyc = 0; cyc < budget && !done; cyc++) begin
      @(negedge clock);
      st = int'(db_estado);
      if (st == 3) begin
        if (prev != 3) n_mostra++;
        run_m++;
        if (!(ativa_leds_mem && toca)) strobe_bad++;
      end else if (prev == 3) begin
        if (run_m < mostra_min) mostra_min = run_m;
        if (run_m > mostra_max) mostra_max = run_m;
        run_m = 0;
      end
      if (erro) erro_cyc++;
      if (st == 10) vidas_erro = int'(vidas);
      if (gravaM) begin
        if (n_grava < 4) grava_addr[n_grava] = int'(endereco);
        n_grava++;
      end
      if ((st == 2 || st == 3) && rodada != 0) late++;
      if (prev == 10 && st == 2) replay_addr = int'(endereco);
      if (st == 6) run_e++; else run_e = 0;
      if (run_e > esp_max) esp_max = run_e;
      jogada_feita = 1'b0;
      if (st == 6 && press_at > 0 && run_e == press_at) begin
        wrong = (rodada == 1 && endereco == 1 && wrongs < n_wrong);
        if (wrong) wrongs++;
        jogada_feita   = 1'b1;
        jogada_correta = !wrong;
      end
      if (st == 11) jogada_feita = 1'b1;
      prev = st;
      if (pronto || (st == stop_st && int'(endereco) == stop_addr)) done = 1'b1;
    end
    jogada_feita = 1'b0;
    check({tag, "_ended"}, int'(done), 1);
  endtask

  initial begin
    // reset state
    #12;
    check("rst_state", db_estado, 0);
    check("rst_end", endereco, 0);
    check("rst_rod", rodada, 0);
    check("rst_vidas", vidas, 2);
    check("rst_strobes", int'({registraR, gravaM, ativa_leds_mem, ativa_leds_jog, toca,
          vez_jogador, nova_jogada, erro, ganhou, perdeu, timeout, pronto}), 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("idle_state", db_estado, 0);

    // all correct, three rounds
    start_game(2, 1'b0, 1'b0);
    run("win", 1, 0, -1, -1, 3000);
    check("win_mostras", n_mostra, 6);
    check("win_mostra_min", mostra_min, 4);
    check("win_mostra_max", mostra_max, 4);
    check("win_mostra_leds", strobe_bad, 0);
    check("win_ganhou", ganhou, 1);
    check("win_pronto", pronto, 1);
    check("win_perdeu", perdeu, 0);
    check("win_rodada", rodada, 2);
    check("win_vidas", vidas, 2);

    // two errors at round 1 entry 1
    start_game(2, 1'b0, 1'b0);
    run("lose", 1, 2, -1, -1, 3000);
    check("lose_erro_cyc", erro_cyc, 4);
    check("lose_vidas_erro", vidas_erro, 1);
    check("lose_replay_addr", replay_addr, 0);
    check("lose_mostras", n_mostra, 5);
    check("lose_state", db_estado, 5'h11);
    check("lose_perdeu", perdeu, 1);
    check("lose_ganhou", ganhou, 0);
    check("lose_vidas", vidas, 0);

    // no press, full timeout
    start_game(2, 1'b0, 1'b0);
    run("to20", 0, 0, -1, -1, 3000);
    check("to20_wait", esp_max, 20);
    check("to20_state", db_estado, 5'h12);
    check("to20_timeout", timeout, 1);
    check("to20_perdeu", perdeu, 1);
    check("to20_vidas", vidas, 2);

    // no press, half timeout
    start_game(2, 1'b1, 1'b0);
    run("to10", 0, 0, -1, -1, 3000);
    check("to10_wait", esp_max, 10);
    check("to10_timeout", timeout, 1);

    // press on the last allowed cycle every time
    start_game(2, 1'b0, 1'b0);
    run("late", 20, 0, -1, -1, 5000);
    check("late_wait", esp_max, 20);
    check("late_state", db_estado, 5'h10);
    check("late_timeout", timeout, 0);

    // record mode
    start_game(3, 1'b0, 1'b1);
    run("grava", 1, 0, -1, -1, 3000);
    check("grava_n", n_grava, 3);
    check("grava_a0", grava_addr[0], 1);
    check("grava_a1", grava_addr[1], 2);
    check("grava_a2", grava_addr[2], 3);
    check("grava_no_show", late, 0);
    check("grava_mostras", n_mostra, 1);
    check("grava_rodada", rodada, 3);
    check("grava_ganhou", ganhou, 1);

    // asynchronous reset in the middle of a show
    start_game(5, 1'b0, 1'b0);
    run("mid", 1, 0, 3, 3, 3000);
    check("mid_pre_state", db_estado, 3);
    check("mid_pre_vidas", vidas, 2);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_state", db_estado, 0);
    check("mid_rst_end", endereco, 0);
    check("mid_rst_rod", rodada, 0);
    check("mid_rst_vidas", vidas, 2);
    @(negedge clock);
    reset = 1'b1;

    // iniciar ignored while waiting for the player
    start_game(2, 1'b0, 1'b0);
    run("wait", 0, 0, 6, 0, 3000);
    iniciar = 1'b1;
    @(negedge clock);
    iniciar = 1'b0;
    check("ign_state", db_estado, 6);
    check("ign_vez", vez_jogador, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/genius_controle_param.md
# genius_controle_param

Parametrised control unit for the sequence-memory game: next generation of the fixed game FSM. Owns its own address, round, show-timer, play-timer and lives counters, so the datapath reduces to memory, comparator and LEDs/buzzer. Adds configurable depth, LED timing, play timeout and multiple lives with sequence replay after an error. Sits between the panel inputs and the datapath memory/comparator.

## Interface
- ADDR_W, 4: address/round width; sequence depth 2^ADDR_W.
- T_ON, 500: cycles a LED stays lit (show, echo and record feedback); ≥2.
- T_OFF, 250: cycles of dark gap before each shown entry; ≥1.
- T_JOGADA, 5000: play timeout in cycles; ≥2, even.
- VIDAS, 3: errors allowed per game, including the fatal one; 1..7.

- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; forces INICIAL.
- iniciar  in  1  start/restart request, level-sampled.
- jogada_feita  in  1  one-cycle pulse: player pressed a key.
- jogada_correta  in  1  comparator result, valid from REGISTRA+1 onward.
- nivel_rodadas  in  ADDR_W  index of final round; latched in PREPARA.
- nivel_tempo  in  1  1 = timeout T_JOGADA/2; latched in PREPARA.
- modo_grava  in  1  1 = player appends new entry each round; latched in PREPARA.
- endereco  out  ADDR_W  memory address.
- rodada  out  ADDR_W  current round index (0-based).
- vidas  out  3  remaining lives.
- registraR, gravaM, ativa_leds_mem, ativa_leds_jog, toca, vez_jogador, nova_jogada, erro  out  1 each  Moore strobes.
- ganhou, perdeu, timeout, pronto  out  1 each  end-of-game flags.
- db_estado  out  5  current state code.

## Operation
- States/codes: INICIAL 00, PREPARA 01, PAUSA 02, MOSTRA 03, INICIO_JOGADA 05, ESPERA_JOGADA 06, REGISTRA 07, FEEDBACK 08, ERRO_VIDA 0A, ESPERA_GRAVACAO 0B, GRAVA 0C, MOSTRA_GRAVACAO 0D, PROXIMA_RODADA 0E, GANHOU 10, PERDEU 11, TIMEOUT 12.
- INICIAL: iniciar → PREPARA.
- PREPARA (1 cycle): endereco←0, rodada←0, vidas←VIDAS, latch nivel_rodadas/nivel_tempo/modo_grava → PAUSA.
- PAUSA: T_OFF cycles dark → MOSTRA.
- MOSTRA: T_ON cycles, ativa_leds_mem=toca=1. At exit: endereco==rodada → INICIO_JOGADA; else endereco++ → PAUSA.
- INICIO_JOGADA (1 cycle): endereco←0, play timer cleared → ESPERA_JOGADA.
- ESPERA_JOGADA: vez_jogador=1, play timer counts. jogada_feita → REGISTRA (wins over timeout in same cycle); else timer reaching limit → TIMEOUT.
- REGISTRA (1 cycle): registraR=1 → FEEDBACK.
- FEEDBACK: T_ON cycles, ativa_leds_jog=toca=1; decision on final cycle:
  - incorrect, vidas>1 → vidas−1, ERRO_VIDA; incorrect, vidas==1 → vidas←0, PERDEU.
  - correct, endereco<rodada → endereco++, play timer cleared → ESPERA_JOGADA.
  - correct, endereco==rodada==latched nivel → GANHOU.
  - correct, endereco==rodada, modo_grava → endereco++ → ESPERA_GRAVACAO; else → PROXIMA_RODADA.
- ERRO_VIDA: T_ON cycles, erro=1, endereco←0 on exit → PAUSA (same round replayed from start).
- ESPERA_GRAVACAO: nova_jogada=1, no timeout; jogada_feita → GRAVA.
- GRAVA (1 cycle): gravaM=1 at endereco=rodada+1 → MOSTRA_GRAVACAO.
- MOSTRA_GRAVACAO: T_ON cycles, ativa_leds_mem=toca=1 → PROXIMA_RODADA.
- PROXIMA_RODADA (1 cycle): rodada++, endereco←0; → INICIO_JOGADA if modo_grava else PAUSA.
- GANHOU/PERDEU/TIMEOUT: ganhou/perdeu/timeout respectively, pronto=1; TIMEOUT also sets perdeu; vidas unchanged by timeout. iniciar → PREPARA.
- iniciar ignored in all non-terminal states; jogada_feita ignored outside ESPERA_JOGADA/ESPERA_GRAVACAO.
- Round counter cannot overflow: nivel_rodadas ≤ 2^ADDR_W−1 and game ends at it; nivel_rodadas=0 → single-entry game.

## Timing
- Reset (async assert, any state): state INICIAL, endereco=0, rodada=0, vidas=VIDAS, all strobes/flags 0, db_estado=0. Release takes effect at next edge.
- All strobes are pure decode of state register; counters registered; no combinational input→output paths.
- Timed state of length D: exactly D cycles, shared in-state timer cleared on every state change.
- Play timer limit: T_JOGADA or T_JOGADA/2; TIMEOUT entered on the edge after limit-th cycle of waiting without a press.
- registraR precedes first comparator-valid cycle by one cycle; decision uses jogada_correta in final FEEDBACK cycle.

## Test plan
- ADDR_W=4,T_ON=4,T_OFF=2,T_JOGADA=20,VIDAS=2; nivel_rodadas=2, all correct → 1+2+3 shown entries, MOSTRA pulses exactly 4 cycles, ganhou=pronto=1, rodada=2.
- Same, wrong on round 1 entry 1 → erro 4 cycles, vidas 2→1, round 1 replayed from endereco 0; second error → perdeu=1, vidas=0.
- No press in ESPERA_JOGADA → timeout=perdeu=1 after 20 cycles; nivel_tempo=1 → after 10; press on cycle 20 → REGISTRA, no timeout.
- modo_grava=1, nivel_rodadas=3 → gravaM pulses with endereco 1,2,3, no PAUSA/MOSTRA after round 0, win at rodada=3.
- reset asserted mid-MOSTRA with endereco=3 → immediate INICIAL, endereco=0, vidas=2; iniciar pulse in ESPERA_JOGADA → no state change.
